instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction-word encoder and instruction-memory writer: the producing end of the instruction format consumed by the control decoder. It accepts symbolic instruction requests (op select plus register and immediate fields) over a valid/ready handshake and packs each into a 32-bit word. It streams the words into instruction memory at auto-incrementing addresses, expanding the MOVE pseudoinstruction into two machine words. It sits between the test/boot loader and the instruction-memory write port.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  load base address, clear count and error flags
- start_addr  in  ADDR_W  base word address
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_op  in  4  0 AND, 1 LW, 2 SW, 3 JR, 4 JAL, 5 NOR, 6 NORI, 7 NOT, 8 BLEU, 9 ROLV, 10 RORV, 11 MOVE, 12–15 illegal
- req_rs, req_rt, req_rd  in  5 each  register fields
- req_imm  in  26  immediate; [15:0] for I-type, [25:0] for J-type
- imem_we  out  1  one-cycle write strobe per word
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded word
- words_written  out  ADDR_W+1  words written since last start
- full  out  1  words_written == 2^ADDR_W
- err_illegal  out  1  sticky: illegal op accepted
- err_overflow  out  1  sticky: MOVE accepted with only one free slot

## Operation
- Opcodes in [31:26]: AND 100000, LW 100011, SW 101011, JR 001000, JAL 000011, NOR 100110, NORI 001110, NOT 000100, BLEU 010000, ROLV 000000, RORV 000010.
- R-type (AND, NOR, ROLV, RORV): rs[25:21], rt[20:16], rd[15:11], [10:0]=0. JR: rs only, all other fields 0. NOT: rt field = rs, rd = rd.
- I-type (LW, SW, NORI, BLEU): rs[25:21], rt[20:16], imm[15:0]=req_imm[15:0]. J-type (JAL): target[25:0]=req_imm.
- MOVE rd, rs expands to NOR rd,rs,rs then NOR rd,rd,rd (words A, B at consecutive addresses).
- FSM: IDLE, MOVE2. IDLE: req_ready = !full & !start_valid. Accept of a single-word op or MOVE-A emits one word next cycle. MOVE accept → MOVE2; MOVE2 (req_ready=0) emits word B → IDLE.
- Write pointer increments mod 2^ADDR_W per emitted word; words_written increments per word; full stops further acceptance, so no slot is overwritten.
- Illegal op: accepted, nothing written, err_illegal set, state stays IDLE.
- MOVE with exactly one free slot: accepted, nothing written, err_overflow set.
- start_valid: highest priority; pointer ← start_addr, words_written ← 0, full and error flags ← 0, FSM ← IDLE (aborts pending MOVE word B). A word whose request was accepted in the previous cycle is still written, at its original address.

## Timing
- Reset: imem_we=0, imem_addr=0, imem_wdata=0, words_written=0, full=0, err_illegal=0, err_overflow=0, req_ready=1, FSM IDLE, pointer 0.
- All outputs registered except req_ready (combinational from state, full, start_valid).
- Latency: accept at edge N → imem_we=1 with addr and data during cycle N+1.
- Throughput: one single-word op per cycle back-to-back; MOVE occupies two cycles (ready low one cycle).
- full asserts in the cycle the final word's imem_we is high.

## Configuration
- INSTR_ENCODER_MOVE_EN defined: MOVE (op 11) expands as above.
- Undefined: op 11 treated as illegal (err_illegal, nothing written); FSM has only IDLE, and err_overflow is tied to 0.

## Test plan
- Reset, start_addr=0x10, AND rd=3 rs=1 rt=2 → next cycle imem_we=1, addr 0x10, data 0x80221800; words_written=1.
- Back-to-back LW rt=4 rs=5 imm=0x0010, then JAL imm=0x40 → 0x8CA40010 @0x10 and 0x0C000040 @0x11 on consecutive cycles, ready never low.
- MOVE rd=7 rs=2 (macro on) → 0x98423800 then 0x98E73800 at consecutive addresses; req_ready=0 for one cycle.
- ADDR_W=2, start_addr=3, four NOR ops → addresses 3,0,1,2; full=1 and req_ready=0 after the fourth; fifth request held.
- req_op=13 → no imem_we, err_illegal=1 until next start_valid; MOVE with one slot free → err_overflow=1, no write.
- start_valid in the MOVE2 cycle → word B not written, pointer=start_addr, flags cleared; rst_n low mid-stream → all outputs to reset values immediately.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction-word encoder: packs symbolic requests into 32-bit words and streams them to imem.
// Optional MOVE pseudo-op expansion is enabled by defining INSTR_ENCODER_MOVE_EN.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [25:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   words_written,
    output logic              full,
    output logic              err_illegal,
    output logic              err_overflow
);

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   ww_inc;
    logic              in_move2, accept, legal, emit, set_ill, set_ovf;
    logic [31:0]       word, wdata;

    assign ww_inc    = words_written + 1'b1;
    assign req_ready = ~in_move2 & ~full & ~start_valid;
    assign accept    = req_valid & req_ready;

    // Single-word encodings; MOVE here produces its first word (NOR rd,rs,rs)
    always_comb begin
        word  = 32'h0;
        legal = 1'b1;
        case (req_op)
            4'd0:    word = {6'b100000, req_rs, req_rt, req_rd, 11'd0};
            4'd1:    word = {6'b100011, req_rs, req_rt, req_imm[15:0]};
            4'd2:    word = {6'b101011, req_rs, req_rt, req_imm[15:0]};
            4'd3:    word = {6'b001000, req_rs, 21'd0};
            4'd4:    word = {6'b000011, req_imm};
            4'd5:    word = {6'b100110, req_rs, req_rt, req_rd, 11'd0};
            4'd6:    word = {6'b001110, req_rs, req_rt, req_imm[15:0]};
            4'd7:    word = {6'b000100, 5'd0, req_rs, req_rd, 11'd0};
            4'd8:    word = {6'b010000, req_rs, req_rt, req_imm[15:0]};
            4'd9:    word = {6'b000000, req_rs, req_rt, req_rd, 11'd0};
            4'd10:   word = {6'b000010, req_rs, req_rt, req_rd, 11'd0};
`ifdef INSTR_ENCODER_MOVE_EN
            4'd11:   word = {6'b100110, req_rs, req_rs, req_rd, 11'd0};
`endif
            default: legal = 1'b0;
        endcase
    end

`ifdef INSTR_ENCODER_MOVE_EN
    typedef enum logic [0:0] {IDLE = 1'b0, MOVE2 = 1'b1} state_t;
    state_t     state, state_nx;
    logic [4:0] move_rd;
    logic       is_move, one_free;

    assign in_move2 = (state == MOVE2);
    assign is_move  = (req_op == 4'd11);
    assign one_free = (words_written == {1'b0, {ADDR_W{1'b1}}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            move_rd <= 5'd0;
        end else begin
            state <= state_nx;
            if (accept && is_move) move_rd <= req_rd;
        end
    end

    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        wdata    = word;
        set_ill  = 1'b0;
        set_ovf  = 1'b0;
        if (start_valid) begin
            state_nx = IDLE;
        end else if (state == MOVE2) begin
            emit     = 1'b1;
            wdata    = {6'b100110, move_rd, move_rd, move_rd, 11'd0};
            state_nx = IDLE;
        end else if (accept) begin
            if (!legal) set_ill = 1'b1;
            else if (is_move && one_free) set_ovf = 1'b1;
            else begin
                emit = 1'b1;
                if (is_move) state_nx = MOVE2;
            end
        end
    end
`else
    assign in_move2 = 1'b0;

    always_comb begin
        emit    = 1'b0;
        wdata   = word;
        set_ill = 1'b0;
        set_ovf = 1'b0;
        if (accept) begin
            if (legal) emit = 1'b1;
            else set_ill = 1'b1;
        end
    end
`endif

    // start_valid only retargets the pointer; a word already registered still goes out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= '0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= 32'h0;
            words_written <= '0;
            full          <= 1'b0;
            err_illegal   <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            imem_we <= emit;
            if (emit) begin
                imem_addr  <= ptr;
                imem_wdata <= wdata;
            end
            if (start_valid) begin
                ptr           <= start_addr;
                words_written <= '0;
                full          <= 1'b0;
                err_illegal   <= 1'b0;
                err_overflow  <= 1'b0;
            end else begin
                if (emit) begin
                    ptr           <= ptr + 1'b1;
                    words_written <= ww_inc;
                    full          <= (ww_inc == CAP);
                end
                if (set_ill) err_illegal  <= 1'b1;
                if (set_ovf) err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: model pushes expected imem writes, a monitor pops and compares.
// Follows INSTR_ENCODER_MOVE_EN the same way as the design build.
module tb_instr_encoder;

    localparam int AW  = 8;
    localparam int CAP = 1 << AW;
`ifdef INSTR_ENCODER_MOVE_EN
    localparam bit MOVE_EN = 1'b1;
`else
    localparam bit MOVE_EN = 1'b0;
`endif

    logic          clk, rst_n, start_valid, req_valid, req_ready;
    logic [AW-1:0] start_addr, imem_addr;
    logic [3:0]    req_op;
    logic [4:0]    req_rs, req_rt, req_rd;
    logic [25:0]   req_imm;
    logic          imem_we, full, err_illegal, err_overflow;
    logic [31:0]   imem_wdata;
    logic [AW:0]   words_written;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_addr(start_addr),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .words_written(words_written), .full(full),
        .err_illegal(err_illegal), .err_overflow(err_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // reference model state
    int  m_ptr, m_cnt;
    bit  m_ill, m_ovf, m_b_pending;
    int  opc_tbl[11] = '{32, 35, 43, 8, 3, 38, 14, 4, 16, 0, 2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input int op, input int rs, input int rt,
                                             input int rd, input int imm);
        longint o, w;
        o = longint'(opc_tbl[op]) * 64'd67108864;
        case (op)
            0, 5, 9, 10: w = o + rs * 2097152 + rt * 65536 + rd * 2048;
            1, 2, 6, 8:  w = o + rs * 2097152 + rt * 65536 + (imm % 65536);
            3:           w = o + rs * 2097152;
            4:           w = o + imm;
            7:           w = o + rs * 65536 + rd * 2048;
            default:     w = 0;
        endcase
        return w[31:0];
    endfunction

    task automatic push(input int addr, input logic [31:0] data);
        wr_t e;
        e.addr = AW'(addr % CAP);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic advance();
        m_ptr = (m_ptr + 1) % CAP;
        m_cnt++;
    endtask

    // One cycle: drive at posedge+1, check ready, step model, check registered status after edge
    task automatic cyc(input bit sv, input int sa, input bit v, input int op,
                       input int rs, input int rt, input int rd, input int imm);
        bit exp_rdy;
        start_valid = sv;  start_addr = AW'(sa);
        req_valid = v;     req_op = 4'(op);
        req_rs = 5'(rs);   req_rt = 5'(rt);   req_rd = 5'(rd);   req_imm = 26'(imm);
        #1;
        exp_rdy = !m_b_pending && (m_cnt < CAP) && !sv;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (sv) begin
            if (m_b_pending) void'(exp_q.pop_back());
            m_b_pending = 0;
            m_ptr = sa % CAP; m_cnt = 0; m_ill = 0; m_ovf = 0;
        end else if (m_b_pending) begin
            m_b_pending = 0;
            advance();
        end else if (v && exp_rdy) begin
            if (op == 11 && MOVE_EN) begin
                if (CAP - m_cnt == 1) m_ovf = 1;
                else begin
                    push(m_ptr, ref_word(5, rs, rs, rd, 0));
                    push(m_ptr + 1, ref_word(5, rd, rd, rd, 0));
                    advance();
                    m_b_pending = 1;
                end
            end else if (op <= 10) begin
                push(m_ptr, ref_word(op, rs, rt, rd, imm));
                advance();
            end else m_ill = 1;
        end
        @(posedge clk); #1;
        chk("words_written", 32'(words_written), 32'(m_cnt));
        chk("full", 32'(full), 32'(m_cnt == CAP));
        chk("err_illegal", 32'(err_illegal), 32'(m_ill));
        chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %h data %h, no write expected", imem_addr, imem_wdata);
            end else begin : pop_one
                wr_t e;
                e = exp_q.pop_front();
                chk("imem_addr", 32'(imem_addr), 32'(e.addr));
                chk("imem_wdata", imem_wdata, e.data);
            end
        end
    end

    initial begin
        rst_n = 1'b0; start_valid = 0; start_addr = '0; req_valid = 0;
        req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0;
        m_ptr = 0; m_cnt = 0; m_ill = 0; m_ovf = 0; m_b_pending = 0;
        @(posedge clk); #1;
        chk("rst_imem_we", 32'(imem_we), 0);
        chk("rst_imem_addr", 32'(imem_addr), 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_words_written", 32'(words_written), 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        rst_n = 1'b1;

        // directed encodings with literal expectations
        cyc(1, 'h10, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 2, 3, 0);
        chk("and_we", 32'(imem_we), 1);
        chk("and_addr", 32'(imem_addr), 'h10);
        chk("and_word", imem_wdata, 32'h80221800);
        cyc(0, 0, 1, 1, 5, 4, 0, 'h0010);
        chk("lw_word", imem_wdata, 32'h8CA40010);
        cyc(0, 0, 1, 4, 0, 0, 0, 'h40);
        chk("jal_word", imem_wdata, 32'h0C000040);
        cyc(0, 0, 1, 11, 2, 0, 7, 0);
        if (MOVE_EN) chk("move_a", imem_wdata, 32'h98423800);
        cyc(0, 0, 1, 5, 1, 1, 1, 0);
        if (MOVE_EN) chk("move_b", imem_wdata, 32'h98E73800);
        cyc(0, 0, 1, 13, 0, 0, 0, 0);
        idle();

        // start during the second MOVE cycle aborts word B
        cyc(0, 0, 1, 11, 9, 0, 10, 0);
        cyc(1, 'h40, 0, 0, 0, 0, 0, 0);
        idle();

        // fill with wrap, overflowing MOVE, last slot, then a held request
        cyc(1, 'hFD, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < CAP - 1; i++) cyc(0, 0, 1, 5, i % 32, (i * 3) % 32, (i * 7) % 32, 0);
        cyc(0, 0, 1, 11, 3, 0, 4, 0);
        cyc(0, 0, 1, 5, 6, 7, 8, 0);
        chk("last_addr", 32'(imem_addr), 'hFC);
        cyc(0, 0, 1, 5, 1, 2, 3, 0);
        idle();

        // asynchronous reset mid-stream
        cyc(1, 'h20, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 14, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 4, 5, 6, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(imem_we), 0);
        chk("mid_rst_addr", 32'(imem_addr), 0);
        chk("mid_rst_wdata", imem_wdata, 0);
        chk("mid_rst_count", 32'(words_written), 0);
        chk("mid_rst_err", 32'(err_illegal), 0);
        exp_q.delete();
        m_ptr = 0; m_cnt = 0; m_ill = 0; m_ovf = 0; m_b_pending = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom % 40) == 0, $urandom % CAP, ($urandom % 4) != 0, $urandom % 16,
                $urandom % 32, $urandom % 32, $urandom % 32, $urandom % (1 << 26));
        end
        idle();
        idle();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
